// File: rtl/Common.sv
// rtl/Common.sv - shared fetch types: raw instruction word, fetch FSM state, buffer entry.
package Common;

  typedef logic [31:0] raw_instr_t;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    raw_instr_t  instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of {instr, pc} entries with flush and same-cycle push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [63:0]                push_data_i,
  input  logic                       pop_i,
  output logic [63:0]                head_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with redirect and buffer.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect halts fetch and raises misalign_o.
module instr_fetch
  import Common::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic          discard_q;
  logic          run_q;
  logic [31:0]   pc_next_d;
  logic [31:0]   redirect_tgt;
  logic          redirect_bad;
  logic [CW-1:0] count;
  logic          req_valid;
  logic          req_hs;
  logic          pending;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign redirect_tgt = redirect_pc_i;
  assign redirect_bad = |redirect_pc_i[1:0];
  assign misalign_o   = misalign_q;
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^redirect_pc_i[1:0];
  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
  assign redirect_bad = 1'b0;
`endif

  assign pc_next_d = pc_q + PC_STEP;
  // run_q holds the request low for the reset cycle itself.
  assign req_valid = run_q && (state_q == FETCH_REQ) && (count < CW'(FIFO_DEPTH));
  assign req_hs    = req_valid && imem_req_ready_i;
  // A request is still in flight after this cycle unless its response lands now.
  assign pending   = req_hs ||
                     (((state_q == FETCH_WAIT) || discard_q) && !imem_resp_valid_i);
  assign push      = (state_q == FETCH_WAIT) && imem_resp_valid_i && !discard_q &&
                     !redirect_valid_i;
  assign pop       = instr_valid_o && instr_ready_i && !redirect_valid_i;

  assign push_entry = '{instr: imem_resp_data_i, pc: req_pc_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      run_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      if (redirect_valid_i) begin
        pc_q      <= redirect_tgt;
        discard_q <= pending;
        if (redirect_bad) begin
          state_q <= FETCH_HALT;
        end else begin
          state_q <= pending ? FETCH_WAIT : FETCH_REQ;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_q <= redirect_bad;
`endif
      end else begin
        case (state_q)
          FETCH_REQ: begin
            if (req_hs) begin
              req_pc_q <= pc_q;
              pc_q     <= pc_next_d;
              state_q  <= FETCH_WAIT;
            end
          end
          FETCH_WAIT: begin
            if (imem_resp_valid_i) begin
              discard_q <= 1'b0;
              state_q   <= FETCH_REQ;
            end
          end
          FETCH_HALT: begin
            if (imem_resp_valid_i) begin
              discard_q <= 1'b0;
            end
          end
          default: state_q <= FETCH_REQ;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_valid_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head_entry),
    .count_o     (count)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign instr_valid_o    = (count != '0);
  assign instr_o          = instr_valid_o ? head_entry.instr : '0;
  assign instr_pc_o       = instr_valid_o ? head_entry.pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hA5C3_0F1E;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .redirect_valid_i  (redirect_valid),
    .redirect_pc_i     (redirect_pc),
    .imem_req_valid_o  (req_valid),
    .imem_req_addr_o   (req_addr),
    .imem_req_ready_i  (req_ready),
    .imem_resp_valid_i (resp_valid),
    .imem_resp_data_i  (resp_data),
    .instr_valid_o     (instr_valid),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_o        (misalign),
`endif
    .instr_ready_i     (instr_ready)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_data[$];
  int          lat = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          n0;
  int          p0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes and pops seen before the edge, then play the memory.
  task automatic cycle();
    bit          hs;
    bit          popped;
    logic [31:0] a;
    logic [31:0] ipc;
    logic [31:0] idat;
    hs     = req_valid && req_ready;
    a      = req_addr;
    popped = instr_valid && instr_ready && !redirect_valid;
    ipc    = instr_pc;
    idat   = instr;
    @(posedge clk);
    #1;
    if (hs) req_log.push_back(a);
    if (popped) begin
      pop_pc.push_back(ipc);
      pop_data.push_back(idat);
    end
    resp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        resp_valid = 1'b1;
        resp_data  = pend_addr ^ K;
        pend       = 1'b0;
      end
    end
    if (hs) begin
      if (lat == 1) begin
        resp_valid = 1'b1;
        resp_data  = a ^ K;
      end else begin
        pend      = 1'b1;
        pend_cnt  = lat - 1;
        pend_addr = a;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_hs();
    int start;
    int k;
    start = req_log.size();
    k = 0;
    while (req_log.size() == start && k < 20) begin
      cycle();
      k++;
    end
    check("wait_hs_timeout", 32'(req_log.size() - start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b1;
    resp_valid     = 1'b0;
    resp_data      = '0;
    instr_ready    = 1'b1;
    #2;
    run(2);
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Sequential fetch from RESET_PC with 1-cycle memory.
    rst_n = 1'b1;
    cycle();
    check("first_req_valid", {31'd0, req_valid}, 32'd1);
    check("first_req_addr", req_addr, 32'h0);
    cycle();
    check("lat_n1_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("lat_n1_one_outstanding", {31'd0, req_valid}, 32'd0);
    cycle();
    check("lat_n2_instr_valid", {31'd0, instr_valid}, 32'd1);
    check("lat_n2_instr_pc", instr_pc, 32'h0);
    check("lat_n2_instr", instr, 32'h0 ^ K);
    run(6);
    check("seq_req0", req_log[0], 32'h0);
    check("seq_req1", req_log[1], 32'h4);
    check("seq_req2", req_log[2], 32'h8);
    check("seq_pop_pc0", pop_pc[0], 32'h0);
    check("seq_pop_pc1", pop_pc[1], 32'h4);
    check("seq_pop_pc2", pop_pc[2], 32'h8);
    check("seq_pop_data2", pop_data[2], 32'h8 ^ K);

    // Backpressure: buffer fills to depth 2, then one pop admits one request.
    req_ready = 1'b0;
    run(4);
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    req_ready      = 1'b1;
    n0 = req_log.size();
    run(12);
    check("full_req_valid", {31'd0, req_valid}, 32'd0);
    check("full_req_count", 32'(req_log.size() - n0), 32'd2);
    check("full_req0", req_log[n0], 32'h40);
    check("full_req1", req_log[n0 + 1], 32'h44);
    check("full_instr_pc", instr_pc, 32'h40);
    check("full_instr", instr, 32'h40 ^ K);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    run(8);
    check("pop1_req_count", 32'(req_log.size() - n0), 32'd3);
    check("pop1_req_addr", req_log[n0 + 2], 32'h48);
    check("pop1_req_valid", {31'd0, req_valid}, 32'd0);
    check("pop1_instr_pc", instr_pc, 32'h44);

    // Redirect while a 2-cycle response is outstanding.
    instr_ready = 1'b1;
    lat = 2;
    run(6);
    wait_hs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    n0 = req_log.size();
    p0 = pop_pc.size();
    cycle();
    redirect_valid = 1'b0;
    run(12);
    check("wait_redir_req", req_log[n0], 32'h100);
    check("wait_redir_pop_pc", pop_pc[p0], 32'h100);
    check("wait_redir_pop_data", pop_data[p0], 32'h100 ^ K);
    check("wait_redir_pop_pc1", pop_pc[p0 + 1], 32'h104);

    // Redirect in the same cycle as the response.
    lat = 1;
    run(4);
    wait_hs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    n0 = req_log.size();
    p0 = pop_pc.size();
    cycle();
    redirect_valid = 1'b0;
    run(10);
    check("resp_redir_req", req_log[n0], 32'h300);
    check("resp_redir_pop_pc", pop_pc[p0], 32'h300);
    check("resp_redir_pop_data", pop_data[p0], 32'h300 ^ K);
    check("resp_redir_pop_pc1", pop_pc[p0 + 1], 32'h304);

    // PC wrap, and request held stable while memory stalls.
    req_ready = 1'b0;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    check("wrap_hold_valid0", {31'd0, req_valid}, 32'd1);
    check("wrap_hold_addr0", req_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_hold_valid1", {31'd0, req_valid}, 32'd1);
    check("wrap_hold_addr1", req_addr, 32'hFFFF_FFFC);
    n0 = req_log.size();
    p0 = pop_pc.size();
    req_ready = 1'b1;
    run(8);
    check("wrap_req0", req_log[n0], 32'hFFFF_FFFC);
    check("wrap_req1", req_log[n0 + 1], 32'h0);
    check("wrap_pop_pc0", pop_pc[p0], 32'hFFFF_FFFC);
    check("wrap_pop_pc1", pop_pc[p0 + 1], 32'h0);
    check("wrap_pop_data1", pop_data[p0 + 1], K);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    n0 = req_log.size();
    run(5);
    check("mis_flag_set", {31'd0, misalign}, 32'd1);
    check("mis_no_reqs", 32'(req_log.size() - n0), 32'd0);
    check("mis_req_valid", {31'd0, req_valid}, 32'd0);
    check("mis_instr_valid", {31'd0, instr_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    p0 = pop_pc.size();
    cycle();
    redirect_valid = 1'b0;
    check("mis_flag_clear", {31'd0, misalign}, 32'd0);
    run(6);
    check("mis_resume_req", req_log[n0], 32'h200);
    check("mis_resume_pop", pop_pc[p0], 32'h200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the instruction buffer depth (power of two, >=2).
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  SHALL be a synchronous, active-low reset.
REQ-005 redirect_valid_i  in  1  SHALL request a PC redirect (branch/jump/trap).
REQ-006 redirect_pc_i  in  32  SHALL carry the redirect target.
REQ-007 imem_req_valid_o  out  1  SHALL indicate a valid fetch request.
REQ-008 imem_req_addr_o  out  32  SHALL carry the fetch address.
REQ-009 imem_req_ready_i  in  1  SHALL indicate that memory accepts the request.
REQ-010 imem_resp_valid_i  in  1  SHALL indicate valid response data.
REQ-011 imem_resp_data_i  in  32 (Common::raw_instr_t)  SHALL carry the fetched word.
REQ-012 instr_valid_o  out  1  SHALL indicate a valid instruction to the decoder.
REQ-013 instr_o  out  32 (Common::raw_instr_t)  SHALL carry the buffer-head instruction.
REQ-014 instr_pc_o  out  32  SHALL carry the PC of instr_o.
REQ-015 instr_ready_i  in  1  SHALL indicate that the decode stage consumes instr_o this cycle.

Function
REQ-016 FSM states FETCH_REQ, FETCH_WAIT and FETCH_HALT SHALL exist, and reset SHALL enter FETCH_REQ.
REQ-017 FETCH_REQ SHALL assert imem_req_valid_o only when buffer occupancy < FIFO_DEPTH, with imem_req_addr_o = pc.
REQ-018 Once asserted, imem_req_valid_o and imem_req_addr_o SHALL be held stable until imem_req_ready_i, except when a redirect changes the address.
REQ-019 A request handshake SHALL record req_pc=pc, set pc=pc+4 mod 2^32 (32'hFFFF_FFFC wraps to 0), and move the FSM to FETCH_WAIT.
REQ-020 At most one request SHALL be outstanding.
REQ-021 In FETCH_WAIT, imem_resp_valid_i SHALL push {resp_data, req_pc} into the buffer unless the discard flag is set, and SHALL return the FSM to FETCH_REQ.
REQ-022 Minimum latency SHALL be: req handshake cycle N, response N+1, instr_valid_o N+2.
REQ-023 instr_valid_o SHALL be asserted whenever the buffer is non-empty, and a pop SHALL occur when instr_valid_o && instr_ready_i.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when the buffer is full.
REQ-025 Redirect SHALL have highest priority: flush the buffer, set pc=redirect_pc_i, and move the FSM to FETCH_REQ, all in the same cycle.
REQ-026 A redirect while a request is outstanding, or coincident with a request handshake, SHALL set discard, and the FSM SHALL go to FETCH_WAIT.
REQ-027 The next response SHALL then be dropped, discard cleared, and the FSM return to FETCH_REQ.
REQ-028 A response arriving in the same cycle as a redirect SHALL be dropped, and SHALL NOT set discard.
REQ-029 A pop coincident with a redirect SHALL be ignored, with no output glitch beyond that cycle.

Reset
REQ-030 When rst_ni=0 at a clock edge, the block SHALL set: pc=RESET_PC, buffer empty, discard=0, FSM=FETCH_REQ.
REQ-031 The same reset SHALL set imem_req_valid_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, and misalign_o=0 when present.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request, and any response in the first cycle after reset SHALL be dropped.

Configuration
REQ-033 With FETCH_MISALIGN_CHECK_EN defined, output port misalign_o (1 bit) SHALL exist.
REQ-034 Under FETCH_MISALIGN_CHECK_EN, a redirect with redirect_pc_i[1:0]!=0 SHALL flush, set misalign_o=1 and enter FETCH_HALT, with no requests issued.
REQ-035 misalign_o SHALL stay set until a redirect with an aligned target, which SHALL clear it and resume fetching.
REQ-036 Without FETCH_MISALIGN_CHECK_EN, misalign_o SHALL be absent, redirect_pc_i[1:0] SHALL be treated as 2'b00, and FETCH_HALT SHALL be unreachable.

Structure
REQ-037 Package Common SHALL hold fetch_state_t (the enum), PC_STEP = 32'd4, and the existing raw_instr_t.
REQ-038 The buffer SHALL be sub-module fetch_fifo, with parameterised depth, payload {raw_instr_t, pc}, flush input, and simultaneous push/pop.

Verification
REQ-039 Reset, then ready=1 and 1-cycle response latency -> addresses 0,4,8 are requested, and instr_pc_o sequence 0,4,8 appears with matching data.
REQ-040 instr_ready_i=0 with FIFO_DEPTH=2 -> two instructions are buffered, then imem_req_valid_o=0; one pop -> exactly one new request.
REQ-041 Redirect to 32'h100 while in FETCH_WAIT -> the stale response is dropped, the next request address is 32'h100, and instr_pc_o=32'h100 appears first.
REQ-042 Redirect coincident with imem_resp_valid_i -> that word never reaches instr_o, and discard is not set (the next response is delivered).
REQ-043 Redirect to 32'hFFFF_FFFC -> requests go to FFFF_FFFC then 0000_0000.
REQ-044 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> misalign_o=1 and no requests; redirect to 32'h200 -> misalign_o=0 and fetch resumes at 32'h200.
